uart_rx_deserializer: RTL and testbench

//  Receive side of the UART link: oversamples serial line RX_IN, detects start bit,

---
 rtl/uart_rx_deserializer.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises RX_IN, majority-votes each oversampled bit, rebuilds the
// LSB-first data word, checks optional parity and the stop bit, and reports one result pulse.
module uart_rx_deserializer #(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE    = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_LENGTH-1:0] P_DATA,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_LENGTH + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] CNT_V2   = CW'(PRESCALE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]          edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]             vote_q, vote_d;
    logic                   sample_q, sample_d;
    logic [DATA_LENGTH-1:0] shift_q, shift_d;
    logic [DATA_LENGTH-1:0] p_data_q, p_data_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   par_bad_q, par_bad_d;
    logic                   data_valid_q, data_valid_d;
    logic                   par_err_q, par_err_d;
    logic                   stp_err_q, stp_err_d;

    logic cnt_last;
    logic vote_now;
    logic majority;

    assign cnt_last = (edge_cnt_q == CNT_LAST);
    assign vote_now = (edge_cnt_q == CNT_V2);
    assign majority = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);

    // NOTE: the synchroniser resets to 1 so a reset never looks like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            vote_q       <= '0;
            sample_q     <= 1'b0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            rx_meta_q    <= RX_IN;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            vote_q       <= vote_d;
            sample_q     <= sample_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!rx_s_q) state_d = S_START;
            S_START:  if (cnt_last) state_d = sample_q ? S_IDLE : S_DATA;
            S_DATA:   if (cnt_last && bit_cnt_q == BIT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (cnt_last) state_d = S_STOP;
            S_STOP:   if (cnt_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: every _d gets a hold/default value first so no path infers a latch.
    always_comb begin
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        vote_d       = vote_q;
        sample_d     = sample_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q == S_IDLE) begin
            // A start bit already low last cycle (back-to-back frame) is one cycle old.
            edge_cnt_d = (!rx_s_q && !rx_prev_q) ? CW'(1) : '0;
            if (!rx_s_q) begin
                par_en_d  = PAR_EN;
                par_typ_d = PAR_TYP;
                par_bad_d = 1'b0;
                bit_cnt_d = '0;
            end
        end else begin
            edge_cnt_d = cnt_last ? '0 : edge_cnt_q + 1'b1;
            if (edge_cnt_q == CNT_V0) vote_d[0] = rx_s_q;
            if (edge_cnt_q == CNT_V1) vote_d[1] = rx_s_q;
            if (vote_now) sample_d = majority;
        end

        case (state_q)
            S_DATA: begin
                if (vote_now) shift_d = (shift_q >> 1) | (DATA_LENGTH'(majority) << (DATA_LENGTH - 1));
                if (cnt_last) bit_cnt_d = bit_cnt_q + 1'b1;
            end
            S_PARITY: begin
                if (vote_now) par_bad_d = majority ^ (^shift_q) ^ par_typ_q;
            end
            S_STOP: begin
                if (cnt_last) begin
                    stp_err_d    = ~sample_q;
                    par_err_d    = sample_q & par_bad_q;
                    data_valid_d = sample_q & ~par_bad_q;
                    if (sample_q && !par_bad_q) p_data_d = shift_q;
                end
            end
            default: ;
        endcase
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frame table, multi-cycle corner
// sequences, and random frames checked against a frame-level reference model.
module tb_uart_rx_deserializer;

    localparam int P = 8;
    localparam int N = 8;

    typedef enum int {K_VALID, K_PAR, K_STP, K_MULTI} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [7:0]  data;
    } pulse_t;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       pb;
        logic       sb;
        kind_e      k;
        logic [7:0] pdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    pulse_t     got_q[$];
    pulse_t     exp_q[$];
    vec_t       vecs[8];
    logic [7:0] prev_pdata = 8'h00;
    logic [7:0] last_good;
    int         n_act;

    uart_rx_deserializer #(.DATA_LENGTH(N), .PRESCALE(P)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .RX_IN     (rx_in),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pulse monitor: every result pulse becomes one record; overlapping or stretched
    // pulses therefore show up as wrong kinds or extra records.
    always @(negedge clk) begin
        if (rst_n) begin
            n_act = int'(data_valid) + int'(par_err) + int'(stp_err);
            if (n_act > 0) begin
                pulse_t r;
                r.cyc  = cyc;
                r.kind = (n_act > 1) ? K_MULTI : data_valid ? K_VALID : par_err ? K_PAR : K_STP;
                r.data = p_data;
                got_q.push_back(r);
            end
            if (p_data != prev_pdata) check("p_data changes only with data_valid", data_valid, 1);
        end
        prev_pdata = p_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "watchdog");
    end

    function automatic kind_e model_kind(input logic [7:0] d, input logic pe, input logic pt,
                                         input logic pb, input logic sb);
        logic want;
        want = (^d) ^ pt;
        if (!sb) return K_STP;
        if (pe && pb != want) return K_PAR;
        return K_VALID;
    endfunction

    function automatic int frame_done(input int fall, input logic pe);
        return fall + 3 + (N + 2 + int'(pe)) * P;
    endfunction

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (P) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic pe, input logic pt, input logic pb,
                               input logic sb, input logic flip, output int fall);
        par_en  = pe;
        par_typ = pt;
        fall    = cyc;
        send_bit(1'b0);
        if (flip) begin
            par_en  = ~pe;
            par_typ = ~pt;
        end
        for (int i = 0; i < N; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        send_bit(sb);
    endtask

    task automatic expect_pulse(input string name, input kind_e k, input logic [7:0] d, input int t);
        pulse_t r;
        check({name, " present"}, 32'(got_q.size() != 0), 32'd1);
        if (got_q.size() != 0) begin
            r = got_q.pop_front();
            check({name, " kind"}, r.kind, k);
            check({name, " p_data"}, r.data, d);
            check({name, " cycle"}, r.cyc, t);
        end
    endtask

    initial begin
        int fall, fall2, gap;
        logic [7:0] d;
        logic pe, pt, pb, sb, flip;
        kind_e k;
        pulse_t e;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'h3C};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, K_PAR,   8'h3C};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, K_STP,   8'h3C};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, K_VALID, 8'h01};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, K_STP,   8'h01};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, K_VALID, 8'hFF};
        vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, K_PAR,   8'hFF};

        #2 rst_n = 1'b0;
        #1;
        check("reset p_data", p_data, 0);
        check("reset data_valid", data_valid, 0);
        check("reset par_err", par_err, 0);
        check("reset stp_err", stp_err, 0);
        check("reset busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 8; i++) begin
            drive_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pb, vecs[i].sb, 1'b0, fall);
            check($sformatf("vec%0d busy in stop bit", i), busy, 1);
            idle(6);
            expect_pulse($sformatf("vec%0d", i), vecs[i].k, vecs[i].pdata, frame_done(fall, vecs[i].pe));
            check($sformatf("vec%0d no extra pulse", i), got_q.size(), 0);
            check($sformatf("vec%0d busy after frame", i), busy, 0);
        end

        // Start-bit glitch: three low cycles must be rejected silently.
        rx_in = 1'b0;
        fall  = cyc;
        repeat (3) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("glitch busy in start", busy, 1);
        idle(P + 4);
        check("glitch busy dropped", busy, 0);
        check("glitch no pulse", got_q.size(), 0);

        // Back-to-back frames with no idle bit between them.
        drive_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        drive_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall2);
        idle(6);
        if (got_q.size() >= 2) check("b2b pulse spacing", got_q[1].cyc - got_q[0].cyc, 80);
        expect_pulse("b2b first", K_VALID, 8'h00, frame_done(fall, 1'b0));
        expect_pulse("b2b second", K_VALID, 8'hFF, frame_done(fall2, 1'b0));
        check("b2b no extra pulse", got_q.size(), 0);

        // Reset in the middle of a frame, held until the aborted frame has passed.
        fork
            drive_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall);
            begin
                repeat (30) @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                check("mid reset p_data", p_data, 0);
                check("mid reset busy", busy, 0);
                check("mid reset data_valid", data_valid, 0);
            end
        join
        idle(4);
        rst_n = 1'b1;
        idle(4);
        check("aborted frame no pulse", got_q.size(), 0);
        drive_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        idle(6);
        expect_pulse("after reset", K_VALID, 8'h81, frame_done(fall, 1'b0));
        check("after reset no extra pulse", got_q.size(), 0);

        // Random frames against the frame-level model.
        last_good = 8'h81;
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom);
            pe   = 1'($urandom_range(0, 1));
            pt   = 1'($urandom_range(0, 1));
            pb   = ((^d) ^ pt) ^ ($urandom_range(0, 3) == 0);
            sb   = ($urandom_range(0, 7) != 0);
            flip = 1'($urandom_range(0, 1));
            drive_frame(d, pe, pt, pb, sb, flip, fall);
            k      = model_kind(d, pe, pt, pb, sb);
            e.cyc  = frame_done(fall, pe);
            e.kind = k;
            if (k == K_VALID) last_good = d;
            e.data = last_good;
            exp_q.push_back(e);
            gap = $urandom_range(0, 10);
            if (gap > 0) idle(gap);
        end
        idle(6);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            expect_pulse($sformatf("rand%0d", i), e.kind, e.data, e.cyc);
        end
        check("random no extra pulse", got_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
